// File: rtl/muldiv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_issue_ctrl
//
// Issue and hazard controller between the execute stage and the shared
// multiplier/divider unit. One HI/LO-class operation is accepted per cycle
// over a valid/ready handshake and turned into single-cycle start pulses for
// the unit. New operations are held off while a divide is in flight. MFHI and
// MFLO results come back on a registered read port. MTHI/MTLO values are kept
// here as override registers because the unit has no HI/LO write path.
//
// State table
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   S_IDLE     | no divide in flight, div_cnt == 0, operations accepted
//   S_DIV_BUSY | divide in flight, div_cnt counting down, op_ready held low
//
// Ports
//   clk            in   clock
//   rst            in   synchronous reset, active high
//   op_valid       in   operation offered
//   op_ready       out  operation accepted this cycle when op_valid && op_ready
//   op_code        in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO,
//                       6 MTHI, 7 MTLO, 8-15 reserved (accepted, no effect)
//   op_a, op_b     in   rs / rt operands
//   md_a, md_b     out  operands to the unit (combinational pass-through)
//   md_enable_mult out  one-cycle multiply start
//   md_enable_div  out  one-cycle divide start
//   md_signed_mult out  signed multiply select
//   md_signed_div  out  signed divide select
//   md_hi, md_lo   in   unit HI / LO
//   rd_valid       out  one-cycle pulse, rd_data carries an MFHI/MFLO result
//   rd_data        out  read result, holds its value between pulses
//   busy           out  divide in flight
// -----------------------------------------------------------------------------
module muldiv_issue_ctrl #(
   parameter int unsigned DIV_LATENCY = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [3:0]  op_code,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   output logic        md_enable_mult,
   output logic        md_enable_div,
   output logic        md_signed_mult,
   output logic        md_signed_div,
   input  logic [31:0] md_hi,
   input  logic [31:0] md_lo,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        busy
);

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MFHI  = 4'd4;
   localparam logic [3:0] OP_MFLO  = 4'd5;
   localparam logic [3:0] OP_MTHI  = 4'd6;
   localparam logic [3:0] OP_MTLO  = 4'd7;

   localparam logic [3:0] DIV_LOAD = 4'(DIV_LATENCY);

   typedef enum logic {
      S_IDLE,
      S_DIV_BUSY
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  div_cnt;
   logic [3:0]  div_cnt_next;

   logic        acc;
   logic        acc_mult;
   logic        acc_div;
   logic        acc_mfhi;
   logic        acc_mflo;
   logic        acc_mthi;
   logic        acc_mtlo;

   logic [31:0] hi_ovr;
   logic [31:0] lo_ovr;
   logic        hi_ov_v;
   logic        lo_ov_v;
   logic [31:0] hi_sel;
   logic [31:0] lo_sel;

   // ---------------------------------------------------------------------------
   // Handshake and decode
   // ---------------------------------------------------------------------------
   assign busy     = (div_cnt != 4'd0);
   assign op_ready = !busy;
   assign acc      = op_valid && op_ready;

   always_comb begin
      acc_mult = 1'b0;
      acc_div  = 1'b0;
      acc_mfhi = 1'b0;
      acc_mflo = 1'b0;
      acc_mthi = 1'b0;
      acc_mtlo = 1'b0;
      if (acc) begin
         unique case (op_code)
            OP_MULT, OP_MULTU: acc_mult = 1'b1;
            OP_DIV,  OP_DIVU:  acc_div  = 1'b1;
            OP_MFHI:           acc_mfhi = 1'b1;
            OP_MFLO:           acc_mflo = 1'b1;
            OP_MTHI:           acc_mthi = 1'b1;
            OP_MTLO:           acc_mtlo = 1'b1;
            default:           ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Unit interface
   // ---------------------------------------------------------------------------
   assign md_a           = op_a;
   assign md_b           = op_b;
   assign md_enable_mult = acc_mult;
   assign md_enable_div  = acc_div;
   assign md_signed_mult = (op_code == OP_MULT);
   assign md_signed_div  = (op_code == OP_DIV);

   // ---------------------------------------------------------------------------
   // Divide-in-flight FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         div_cnt <= 4'd0;
      end else begin
         state   <= state_next;
         div_cnt <= div_cnt_next;
      end
   end

   always_comb begin
      state_next   = state;
      div_cnt_next = div_cnt;
      unique case (state)
         S_IDLE: begin
            // A divide can only be accepted here because op_ready is low
            // throughout S_DIV_BUSY.
            if (acc_div && (DIV_LOAD != 4'd0)) begin
               div_cnt_next = DIV_LOAD;
               state_next   = S_DIV_BUSY;
            end
         end
         S_DIV_BUSY: begin
            div_cnt_next = div_cnt - 4'd1;
            if (div_cnt <= 4'd1) begin
               div_cnt_next = 4'd0;
               state_next   = S_IDLE;
            end
         end
         default: begin
            div_cnt_next = 4'd0;
            state_next   = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // MTHI/MTLO overrides. Any new multiply or divide will rewrite HI/LO in the
   // unit, so it invalidates both overrides.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_ovr  <= 32'd0;
         lo_ovr  <= 32'd0;
         hi_ov_v <= 1'b0;
         lo_ov_v <= 1'b0;
      end else if (acc_mult || acc_div) begin
         hi_ov_v <= 1'b0;
         lo_ov_v <= 1'b0;
      end else begin
         if (acc_mthi) begin
            hi_ovr  <= op_a;
            hi_ov_v <= 1'b1;
         end
         if (acc_mtlo) begin
            lo_ovr  <= op_a;
            lo_ov_v <= 1'b1;
         end
      end
   end

   assign hi_sel = hi_ov_v ? hi_ovr : md_hi;
   assign lo_sel = lo_ov_v ? lo_ovr : md_lo;

   // ---------------------------------------------------------------------------
   // Registered read port
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_data  <= 32'd0;
      end else begin
         rd_valid <= acc_mfhi || acc_mflo;
         if (acc_mfhi) begin
            rd_data <= hi_sel;
         end else if (acc_mflo) begin
            rd_data <= lo_sel;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
module tb_muldiv_issue_ctrl;

   localparam int DIV_LAT = 11;

   logic        clk;
   logic        rst;
   logic        op_valid;
   logic        op_ready;
   logic [3:0]  op_code;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        md_enable_mult;
   logic        md_enable_div;
   logic        md_signed_mult;
   logic        md_signed_div;
   logic [31:0] md_hi;
   logic [31:0] md_lo;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] exp_q[$];

   muldiv_issue_ctrl #(.DIV_LATENCY(DIV_LAT)) dut (
      .clk(clk), .rst(rst),
      .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
      .op_a(op_a), .op_b(op_b),
      .md_a(md_a), .md_b(md_b),
      .md_enable_mult(md_enable_mult), .md_enable_div(md_enable_div),
      .md_signed_mult(md_signed_mult), .md_signed_div(md_signed_div),
      .md_hi(md_hi), .md_lo(md_lo),
      .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural multiplier/divider unit ----------------
   function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
      logic [63:0] ea, eb;
      ea = s ? {{32{a[31]}}, a} : {32'd0, a};
      eb = s ? {{32{b[31]}}, b} : {32'd0, b};
      return ea * eb;
   endfunction

   function automatic logic [31:0] quo(input logic [31:0] a, input logic [31:0] b,
                                       input logic s);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (s) return 32'(sa / sb);
      return a / b;
   endfunction

   function automatic logic [31:0] rem(input logic [31:0] a, input logic [31:0] b,
                                       input logic s);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (s) return 32'(sa % sb);
      return a % b;
   endfunction

   logic [31:0] pend_hi, pend_lo;
   int          ucnt;

   always @(posedge clk) begin
      if (rst) begin
         md_hi <= 32'd0;
         md_lo <= 32'd0;
         ucnt  <= 0;
      end else if (md_enable_mult) begin
         {md_hi, md_lo} <= mul64(md_a, md_b, md_signed_mult);
      end else if (md_enable_div) begin
         md_hi   <= 32'hBAD0_0BAD;
         md_lo   <= 32'hBAD0_0BAD;
         pend_hi <= rem(md_a, md_b, md_signed_div);
         pend_lo <= quo(md_a, md_b, md_signed_div);
         ucnt    <= DIV_LAT;
      end else if (ucnt != 0) begin
         ucnt <= ucnt - 1;
         if (ucnt == 1) begin
            md_hi <= pend_hi;
            md_lo <= pend_lo;
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Read-port scoreboard: every rd_valid pulse must match the oldest
   // outstanding MFHI/MFLO expectation.
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("rd_unexpected", 32'd1, 32'd0);
         end else begin
            chk("rd_data", rd_data, exp_q.pop_front());
         end
      end
   end

   typedef struct {
      logic [3:0]  code;
      logic [31:0] a;
      logic [31:0] b;
      logic        en_m;
      logic        en_d;
      logic        sm;
      logic        sd;
      logic        rd;
      logic [31:0] rdat;
      int          stall;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] code, input logic [31:0] a,
                               input logic [31:0] b, input logic en_m, input logic en_d,
                               input logic sm, input logic sd, input logic rd,
                               input logic [31:0] rdat, input int stall);
      vec_t v;
      v.code = code; v.a = a; v.b = b;
      v.en_m = en_m; v.en_d = en_d; v.sm = sm; v.sd = sd;
      v.rd = rd; v.rdat = rdat; v.stall = stall;
      return v;
   endfunction

   // Called just after a falling edge; returns at the falling edge after the
   // op was accepted, with op_valid dropped.
   task automatic issue(input vec_t v, input string tag);
      int stalls;
      stalls   = 0;
      op_valid = 1'b1;
      op_code  = v.code;
      op_a     = v.a;
      op_b     = v.b;
      #1;
      while (!op_ready) begin
         chk({tag, "_stall_en"}, {30'd0, md_enable_mult, md_enable_div}, 32'd0);
         @(negedge clk);
         #1;
         stalls++;
         if (stalls > 40) break;
      end
      chk({tag, "_stall_cycles"}, 32'(stalls), 32'(v.stall));
      chk({tag, "_en_mult"}, {31'd0, md_enable_mult}, {31'd0, v.en_m});
      chk({tag, "_en_div"}, {31'd0, md_enable_div}, {31'd0, v.en_d});
      chk({tag, "_signed_mult"}, {31'd0, md_signed_mult}, {31'd0, v.sm});
      chk({tag, "_signed_div"}, {31'd0, md_signed_div}, {31'd0, v.sd});
      chk({tag, "_md_a"}, md_a, v.a);
      chk({tag, "_md_b"}, md_b, v.b);
      if (v.rd) exp_q.push_back(v.rdat);
      @(negedge clk);
      op_valid = 1'b0;
      chk({tag, "_rd_valid"}, {31'd0, rd_valid}, {31'd0, v.rd});
   endtask

   vec_t vecs[18];

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //                code   a             b             enM enD sM sD rd  rdata         stall
      vecs[0]  = mk(4'd0, 32'hFFFF_FFFD, 32'd5,        1, 0, 1, 0, 0, 32'h0,         0);
      vecs[1]  = mk(4'd5, 32'h0,         32'h0,        0, 0, 0, 0, 1, 32'hFFFF_FFF1, 0);
      vecs[2]  = mk(4'd4, 32'h0,         32'h0,        0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
      vecs[3]  = mk(4'd2, 32'd7,         32'hFFFF_FFFE, 0, 1, 0, 1, 0, 32'h0,         0);
      vecs[4]  = mk(4'd5, 32'h0,         32'h0,        0, 0, 0, 0, 1, 32'hFFFF_FFFD, DIV_LAT);
      vecs[5]  = mk(4'd4, 32'h0,         32'h0,        0, 0, 0, 0, 1, 32'h0000_0001, 0);
      vecs[6]  = mk(4'd3, 32'hFFFF_FFFF, 32'h10,       0, 1, 0, 0, 0, 32'h0,         0);
      vecs[7]  = mk(4'd5, 32'h0,         32'h0,        0, 0, 0, 0, 1, 32'h0FFF_FFFF, DIV_LAT);
      vecs[8]  = mk(4'd4, 32'h0,         32'h0,        0, 0, 0, 0, 1, 32'h0000_000F, 0);
      vecs[9]  = mk(4'd6, 32'h0000_1234, 32'h0,        0, 0, 0, 0, 0, 32'h0,         0);
      vecs[10] = mk(4'd7, 32'hCAFE_BABE, 32'h0,        0, 0, 0, 0, 0, 32'h0,         0);
      vecs[11] = mk(4'd4, 32'h0,         32'h0,        0, 0, 0, 0, 1, 32'h0000_1234, 0);
      vecs[12] = mk(4'd5, 32'h0,         32'h0,        0, 0, 0, 0, 1, 32'hCAFE_BABE, 0);
      vecs[13] = mk(4'hC, 32'hDEAD_BEEF, 32'h5555_0000, 0, 0, 0, 0, 0, 32'h0,        0);
      vecs[14] = mk(4'd4, 32'h0,         32'h0,        0, 0, 0, 0, 1, 32'h0000_1234, 0);
      vecs[15] = mk(4'd1, 32'd2,         32'd3,        1, 0, 0, 0, 0, 32'h0,         0);
      vecs[16] = mk(4'd4, 32'h0,         32'h0,        0, 0, 0, 0, 1, 32'h0000_0000, 0);
      vecs[17] = mk(4'd5, 32'h0,         32'h0,        0, 0, 0, 0, 1, 32'h0000_0006, 0);

      rst      = 1'b1;
      op_valid = 1'b0;
      op_code  = 4'd0;
      op_a     = 32'd0;
      op_b     = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_enables", {30'd0, md_enable_mult, md_enable_div}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 18; i++) begin
         issue(vecs[i], $sformatf("v%0d", i));
         if (i == 13) chk("reserved_busy", {31'd0, busy}, 32'd0);
      end

      // Reset four cycles into a divide abandons it.
      issue(mk(4'd2, 32'd100, 32'd7, 0, 1, 0, 1, 0, 32'h0, 0), "rdiv");
      repeat (3) @(negedge clk);
      chk("rdiv_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rdiv_busy", {31'd0, busy}, 32'd0);
      chk("rdiv_op_ready", {31'd0, op_ready}, 32'd1);
      chk("rdiv_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rdiv_rd_data", rd_data, 32'd0);
      issue(mk(4'd1, 32'd3, 32'd3, 1, 0, 0, 0, 0, 32'h0, 0), "rmul");
      issue(mk(4'd5, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h0000_0009, 0), "rmflo");

      repeat (3) @(negedge clk);
      chk("rd_pending", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
Issue and hazard controller placed between the execute stage and the multiplier/divider unit. It accepts one HI/LO-class operation per cycle (MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO) over a valid/ready handshake and turns it into single-cycle enable pulses for the unit. It holds back new operations while a division is in flight, and returns MFHI/MFLO results on a registered read port. It also holds the MTHI/MTLO override registers, because the unit has no direct HI/LO write path.

Parameters:
DIV_LATENCY, 11, cycles from the md_enable_div edge until md_hi/md_lo hold the quotient/remainder; must match the unit.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
op_valid  in  1  operation offered
op_ready  out  1  operation accepted this cycle when op_valid&&op_ready
op_code  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO, 8-15 reserved
op_a  in  32  rs operand
op_b  in  32  rt operand
md_a  out  32  operand A to unit (drives multA and divA)
md_b  out  32  operand B to unit (drives multB and divB)
md_enable_mult  out  1  one-cycle multiply start
md_enable_div  out  1  one-cycle divide start
md_signed_mult  out  1  signed multiply select
md_signed_div  out  1  signed divide select
md_hi  in  32  unit HI
md_lo  in  32  unit LO
rd_valid  out  1  read result valid (one-cycle pulse)
rd_data  out  32  MFHI/MFLO result
busy  out  1  divide in flight

Behaviour:
- Accept: acc = op_valid && op_ready. op_ready = !busy, combinational.
- md_a/md_b = op_a/op_b, combinational pass-through.
- md_enable_mult = acc && op_code ∈ {0,1}; md_signed_mult = (op_code==0).
- md_enable_div = acc && op_code ∈ {2,3}; md_signed_div = (op_code==2).
- All enables are 0 when not accepted.
- Divide counter div_cnt (4 bits):
  - Loaded with DIV_LATENCY on the edge where a DIV/DIVU is accepted.
  - Otherwise decrements when nonzero.
  - busy = (div_cnt != 0).
- States:
  - IDLE: div_cnt==0.
  - DIV_BUSY: div_cnt>0. Returns to IDLE on the edge where div_cnt goes 1→0.
  - Result timing: DIV accepted at edge T → op_ready low for cycles T+1..T+DIV_LATENCY → op_ready high in cycle T+DIV_LATENCY+1, with md_hi/md_lo valid.
- Multiply: no stall. md_hi/md_lo are valid in the cycle after acceptance, so back-to-back MULT then MFLO is legal.
- Override registers hi_ovr/lo_ovr (32b) with flags hi_ov_v/lo_ov_v:
  - MTHI accepted: hi_ovr<=op_a, hi_ov_v<=1.
  - MTLO accepted: lo_ovr<=op_a, lo_ov_v<=1.
  - Any accepted MULT/MULTU/DIV/DIVU clears both flags on the same edge.
- Reads:
  - MFHI accepted at edge T: rd_valid=1 and rd_data = hi_ov_v ? hi_ovr : md_hi, registered, visible in the cycle after T.
  - MFLO: same, using the lo path.
  - rd_valid is a single-cycle pulse. rd_data holds its last value when rd_valid=0.
- Reserved op_code 8-15: accepted (op_ready is honoured), no side effects, no rd_valid.
- Sign/width: the controller does no arithmetic. Signedness is carried only on md_signed_*.
- Reset (any cycle, including mid-divide), state after the edge:
  - div_cnt=0, busy=0, op_ready=1.
  - rd_valid=0, rd_data=0.
  - hi_ovr=lo_ovr=0, both flags 0.
  - md enables low.
  - An in-flight divide is abandoned. The unit is reset by the same rst.
- op_valid held high while op_ready=0: the op is not consumed and no pulse is issued. The op issues exactly once, in the first ready cycle.

Test Plan:
- MULT op_a=0xFFFFFFFD, op_b=5, then MFLO, then MFHI → md_enable_mult pulse with md_signed_mult=1; rd_data 0xFFFFFFF1, then 0xFFFFFFFF; no stall cycles.
- DIV op_a=7, op_b=0xFFFFFFFE, then MFLO offered immediately → op_ready low for exactly 11 cycles; MFLO then issues; rd_data=0xFFFFFFFD, then MFHI returns 0x00000001.
- DIVU 0xFFFFFFFF/0x10 → md_signed_div=0; MFLO=0x0FFFFFFF; MFHI=0x0000000F.
- MTHI 0x00001234, MTLO 0xCAFEBABE, MFHI, MFLO → 0x00001234 and 0xCAFEBABE. Then MULTU 2*3 and MFLO → 0x00000006 (overrides cleared).
- rst asserted 4 cycles into a DIV → next cycle busy=0, op_ready=1, rd_valid=0. A subsequent MULTU 3*3 and MFLO → 0x00000009 with no stall.
- Reserved op_code 0xC with op_valid=1 → accepted in 1 cycle; no enables, no rd_valid; override and counter state unchanged.
